// File: rtl/ring_decoder.sv
// Decodes and sequence-checks a one-hot right-rotating ring counter; 1-cycle registered latency, no backpressure.
// Optional saturating error counter port err_cnt is present when RING_DEC_ERRCNT_EN is defined.
module ring_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
`ifdef RING_DEC_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic [CNT_W-1:0] rev_cnt
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic [IDX_W-1:0] idx_dec;
  logic             one_hot;
  logic             accept;
  logic             bad;
  logic             wrap;

  assign expected = {prev[0], prev[WIDTH-1:1]};
  assign one_hot  = $onehot(ring_in);
  assign locked   = (state == LOCKED);

  always_comb begin
    idx_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) idx_dec = IDX_W'(i);
    end
  end

  // In LOCKED, prev is one-hot, so matching the rotation implies legality.
  always_comb begin
    accept = 1'b0;
    if (in_valid) accept = (state == HUNT) ? one_hot : (ring_in == expected);
  end

  assign bad  = in_valid && !accept;
  assign wrap = accept && (state == LOCKED) && prev[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      prev      <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      err       <= 1'b0;
      rev_cnt   <= '0;
    end else begin
      idx_valid <= accept;
      err       <= bad;
      if (accept) begin
        state   <= LOCKED;
        prev    <= ring_in;
        idx_out <= idx_dec;
      end else if (bad) begin
        state <= HUNT;
      end
      if (wrap) rev_cnt <= rev_cnt + 1'b1;
    end
  end

`ifdef RING_DEC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bad && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed and short randomised bench for ring_decoder; two instances (CNT_W=8 and CNT_W=2) share stimulus.
module tb_ring_decoder;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] ring_in = 4'b0000;

  logic [1:0] idx_b, idx_s;
  logic       iv_b, iv_s, lk_b, lk_s, er_b, er_s;
  logic [7:0] rev_b;
  logic [1:0] rev_s;
`ifdef RING_DEC_ERRCNT_EN
  logic [7:0] ecnt_b;
  logic [1:0] ecnt_s;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ring_decoder #(.WIDTH(W), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
    .idx_out(idx_b), .idx_valid(iv_b), .locked(lk_b), .err(er_b),
`ifdef RING_DEC_ERRCNT_EN
    .err_cnt(ecnt_b),
`endif
    .rev_cnt(rev_b)
  );

  ring_decoder #(.WIDTH(W), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
    .idx_out(idx_s), .idx_valid(iv_s), .locked(lk_s), .err(er_s),
`ifdef RING_DEC_ERRCNT_EN
    .err_cnt(ecnt_s),
`endif
    .rev_cnt(rev_s)
  );

  // Model: position of the last accepted sample, -1 while hunting.
  int m_pos = -1;
  int m_idx = 0;
  bit m_iv = 1'b0;
  bit m_err = 1'b0;
  int m_rev = 0;
  int m_errs = 0;

  always @(posedge clk) begin
    int n, pos;
    if (rst) begin
      m_pos = -1; m_idx = 0; m_iv = 0; m_err = 0; m_rev = 0; m_errs = 0;
    end else begin
      m_iv = 0;
      m_err = 0;
      if (in_valid) begin
        n = $countones(ring_in);
        pos = 0;
        for (int i = 0; i < W; i++) if (ring_in[i]) pos = i;
        if (n == 1 && (m_pos < 0 || pos == (m_pos + W - 1) % W)) begin
          if (m_pos == 0) m_rev++;
          m_pos = pos;
          m_idx = pos;
          m_iv = 1;
        end else begin
          m_pos = -1;
          m_err = 1;
          m_errs++;
        end
      end
    end
  end

  function automatic void chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("idx_b", idx_b, m_idx);
      chk("idx_s", idx_s, m_idx);
      chk("idx_valid_b", iv_b, m_iv);
      chk("idx_valid_s", iv_s, m_iv);
      chk("locked_b", lk_b, m_pos >= 0);
      chk("locked_s", lk_s, m_pos >= 0);
      chk("err_b", er_b, m_err);
      chk("err_s", er_s, m_err);
      chk("rev_b", rev_b, m_rev % 256);
      chk("rev_s", rev_s, m_rev % 4);
      chk("pulse_exclusive", iv_b & er_b, 0);
`ifdef RING_DEC_ERRCNT_EN
      chk("err_cnt_b", ecnt_b, (m_errs > 255) ? 255 : m_errs);
      chk("err_cnt_s", ecnt_s, (m_errs > 3) ? 3 : m_errs);
`endif
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] d);
    rst = r; in_valid = v; ring_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);
  endtask

  logic [3:0] clean_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  int         clean_idx [5] = '{3, 2, 1, 0, 3};
  logic [3:0] cur;

  initial begin
    // Reset: a sample presented on the reset edge is discarded.
    step(1'b1, 1'b1, 4'b1000);
    chk_en = 1'b1;
    chk("rst_idx", idx_b, 0);
    chk("rst_lock", lk_b, 0);
    chk("rst_iv", iv_b, 0);
    chk("rst_err", er_b, 0);
    chk("rst_rev", rev_b, 0);
    step(1'b0, 1'b0, 4'b0000);

    // Clean rotation.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, clean_seq[i]);
      chk("clean_idx", idx_b, clean_idx[i]);
      chk("clean_lock", lk_b, 1);
      chk("clean_err", er_b, 0);
    end
    chk("clean_rev", rev_b, 1);

    // Sequence break and relock.
    do_reset();
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b0001);
    chk("skip_err", er_b, 1);
    chk("skip_lock", lk_b, 0);
    chk("skip_idx", idx_b, 2);
    step(1'b0, 1'b1, 4'b0010);
    chk("relock_idx", idx_b, 1);
    chk("relock_iv", iv_b, 1);
    chk("relock_err", er_b, 0);
    step(1'b0, 1'b1, 4'b0010);
    chk("repeat_err", er_b, 1);

    // Illegal patterns while hunting.
    do_reset();
    step(1'b0, 1'b1, 4'b0000);
    chk("zero_err", er_b, 1);
    chk("zero_lock", lk_b, 0);
    step(1'b0, 1'b1, 4'b0110);
    chk("two_err", er_b, 1);
    chk("two_iv", iv_b, 0);
`ifdef RING_DEC_ERRCNT_EN
    chk("illegal_cnt", ecnt_b, 2);
`endif

    // Gaps are not errors.
    do_reset();
    step(1'b0, 1'b1, 4'b1000);
    chk("gap_idx0", idx_b, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b0001);
      chk("gap_iv", iv_b, 0);
      chk("gap_lock", lk_b, 1);
      chk("gap_err", er_b, 0);
    end
    step(1'b0, 1'b1, 4'b0100);
    chk("gap_idx1", idx_b, 2);
    chk("gap_err2", er_b, 0);

    // Revolution wrap on the 2-bit counter, then reset mid-rotation.
    do_reset();
    step(1'b0, 1'b1, 4'b1000);
    chk("wrap_rev0", rev_s, 0);
    for (int r = 1; r <= 5; r++) begin
      step(1'b0, 1'b1, 4'b0100);
      step(1'b0, 1'b1, 4'b0010);
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b1000);
      chk("wrap_rev", rev_s, r % 4);
    end
    chk("wrap_rev_big", rev_b, 5);
    step(1'b0, 1'b1, 4'b0100);
    step(1'b1, 1'b1, 4'b0010);
    chk("mid_rst_idx", idx_b, 0);
    chk("mid_rst_lock", lk_b, 0);
    chk("mid_rst_rev", rev_s, 0);
    step(1'b0, 1'b1, 4'b0010);
    chk("mid_relock_idx", idx_b, 1);
    chk("mid_relock_rev", rev_s, 0);
    step(1'b0, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b1000);
    chk("mid_wrap_rev", rev_s, 1);

    // Error counter saturation on the 2-bit instance.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 4'b1111);
      chk("sat_err", er_s, 1);
`ifdef RING_DEC_ERRCNT_EN
      chk("sat_cnt", ecnt_s, (i > 3) ? 3 : i);
`endif
    end

    // Mixed traffic, checked against the model only.
    do_reset();
    cur = 4'b0001;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) cur = {cur[0], cur[3:1]};
      else cur = 4'($urandom_range(0, 15));
      step(1'b0, ($urandom_range(0, 4) != 0), cur);
      if (!$onehot(cur)) cur = 4'b0001;
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side decoder and checker for the 4-bit one-hot ring counter sequence produced elsewhere in this design. Each valid sample is decoded to a binary index and checked against the expected right rotation. The block tracks lock state and counts completed revolutions. It sits downstream of a ring counter and flags any sample that breaks the rotation sequence.

## Interface
Parameters:
- WIDTH, default 4: ring width in bits; must be at least 2.
- CNT_W, default 8: width of the revolution and error counters.

Ports:
- clk, input, 1: the single clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: ring_in carries a sample this cycle.
- ring_in, input, WIDTH: the ring counter value.
- idx_out, output, $clog2(WIDTH): position of the set bit in the last accepted legal sample.
- idx_valid, output, 1: idx_out was updated by the previous edge.
- locked, output, 1: the decoder is tracking a valid rotation.
- err, output, 1: one-cycle pulse on an illegal or out-of-sequence sample.
- rev_cnt, output, CNT_W: number of completed revolutions.
- err_cnt, output, CNT_W: saturating error count. This port exists only when RING_DEC_ERRCNT_EN is defined.

## Operation
- A legal sample has exactly one bit set (one-hot). The index is the position of that bit, so 1000 decodes to 3 and 0001 decodes to 0.
- The rotation direction is right rotate. After sample p, the expected next sample is {p[0], p[WIDTH-1:1]}, giving the sequence 1000, 0100, 0010, 0001, 1000.
- The block stores prev, the last accepted legal sample.
- FSM state HUNT, the reset state:
  - in_valid with a legal sample: store it in prev, update idx_out, pulse idx_valid, go to LOCKED.
  - in_valid with an illegal sample (zero bits or two or more bits set): pulse err, stay in HUNT, leave idx_out unchanged.
- FSM state LOCKED:
  - in_valid with ring_in equal to the expected next sample: store it in prev, update idx_out, pulse idx_valid, stay in LOCKED.
  - If that accepted sample moves from index 0 to index WIDTH-1, increment rev_cnt.
  - in_valid with any other value (including a repeat of prev, a legal but skipped position, or an illegal pattern): pulse err, idx_valid=0, go to HUNT.
  - There is no same-cycle relock after an error. The next legal sample relocks.
- in_valid=0: no check is made, state and prev hold, idx_valid=0, err=0. Gaps between samples are allowed and are not errors.
- rev_cnt wraps modulo 2^CNT_W. It is not cleared by errors or by losing lock; only rst clears it.
- idx_out holds its last value until the next accepted sample.

## Timing
- All outputs are registered. A sample presented at edge N produces its response at edge N, which is visible during cycle N+1. Latency is 1 cycle.
- idx_valid and err are single-cycle pulses and are never both 1 in the same cycle.
- locked=1 exactly when the state is LOCKED. It rises in the same cycle as the first idx_valid and falls in the same cycle as err.
- rev_cnt updates in the same cycle as the idx_valid pulse for the wrapping sample.
- Reset values: state HUNT, prev 0, idx_out 0, idx_valid 0, locked 0, err 0, rev_cnt 0, err_cnt 0.
- rst has priority over in_valid. A sample presented on a reset edge is discarded.
- A reset mid-rotation requires a fresh lock, and the first sample after that relock does not count as a wrap.

## Configuration
- Macro: RING_DEC_ERRCNT_EN.
- With the macro defined:
  - The err_cnt port and its register exist.
  - err_cnt increments on every err pulse and saturates at 2^CNT_W-1.
  - err_cnt is cleared only by rst.
- Without the macro: the err_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Clean rotation: reset, then 1000, 0100, 0010, 0001, 1000 on consecutive cycles with in_valid=1. Required: idx_out 3,2,1,0,3; locked from the first sample; err never asserted; rev_cnt=1 after the fifth sample.
- Sequence break: while locked at 0100, present 0001 (a skip). Required: err pulses, locked=0, idx_out stays 2. Then present 0010: relock with idx_out=1 and no err.
- Illegal patterns: present 0000, then 0110, while in HUNT. Required: err pulses on each, locked stays 0, idx_valid stays 0. With the macro defined, err_cnt=2.
- Gaps: 1000, then in_valid=0 for 3 cycles, then 0100. Required: no err, idx_valid 0 during the gap, locked held, idx_out 3 then 2.
- Wrap and reset: CNT_W=2, run 4 full revolutions, then 1 more. Required: rev_cnt 0,1,2,3,0,1. Assert rst mid-rotation: all outputs return to reset values on the next edge, and 0010 then relocks with no revolution counted.
- Error counter saturation (macro defined, CNT_W=2): present 5 illegal samples. Required: err_cnt reads 1,2,3,3,3.
